execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline, directly upstream of the memory stage.
- Resolves the forwarding muxes, runs the ALU and the branch comparator, and computes the branch/jump target and PCSrc.
- Registers all memory-stage inputs in an internal execute-to-memory pipeline register with stall and flush control.

Parameters:
D_WIDTH, 32, datapath width
A_WIDTH, 5, register-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
StallE  in  1  hold the EX/MEM register
FlushE  in  1  insert bubble into the EX/MEM register
RegWriteE  in  1  register-file write enable
MemWriteE  in  1  data-memory write enable
a_typeE  in  1  byte-access type for data memory
JumpE  in  1  JAL or JALR
JalrE  in  1  JALR (target from ALU)
BranchE  in  1  conditional branch
BranchTypeE  in  3  funct3 of the branch
ResultSrcE  in  2  writeback select
ALUControlE  in  4  ALU operation
ALUSrcE  in  1  1 = ImmExtE as operand B
ForwardAE  in  2  00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE  in  2  same encoding as ForwardAE, for RD2E
RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW  in  D_WIDTH  operands
RdE  in  A_WIDTH  destination register
PCSrcE  out  1  redirect fetch
PCTargetE  out  D_WIDTH  redirect address
RegWriteM, MemWriteM, a_typeM  out  1  registered controls
ResultSrcM  out  2  registered writeback select
RdM  out  A_WIDTH  registered destination register
ALUResultM, WriteDataM, PCPlus4M  out  D_WIDTH  registered data

Behaviour:
- Forwarding
  - SrcA = mux(ForwardAE); ForwardAE = 11 selects RD1E.
  - The ALUResultM leg uses this block's own registered output.
  - WriteDataE = forwarded B before the ALUSrc mux.
  - SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- ALU encoding (combinational; shifts use SrcB[4:0]):
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt (signed, result 0/1), 0110 sltu
  - 0111 sll, 1000 srl, 1001 sra
  - 1010 pass SrcB (LUI)
  - all others → 0
  - Add/sub wrap modulo 2^32; no flags are exported.
- Branch condition, from BranchTypeE on SrcA/WriteDataE:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - 010 and 011 → never taken.
- PCSrcE = JumpE | (BranchE & cond).
- PCTargetE:
  - JalrE = 1: ALUResult & ~1 (bit 0 cleared).
  - otherwise: PCE + ImmExtE, wrapping.
- PCSrcE and PCTargetE are combinational, zero latency, and unaffected by StallE/FlushE.
- EX/MEM register updates on the rising clk edge, priority rst > FlushE > StallE > load:
  - rst: all M outputs ← 0.
  - FlushE: RegWriteM, MemWriteM ← 0; ResultSrcM ← 00; RdM ← 0. Data fields are don't-care; the implementation clears them to 0.
  - StallE (no flush): all M outputs hold.
  - Else: capture the E-stage values (ALUResultM ← ALU result, WriteDataM ← WriteDataE, PCPlus4M, RdM, and the controls).
- Latency: E inputs appear on the M outputs one cycle later.
- Reset mid-operation discards any in-flight instruction; the first instruction after reset deassertion sees ALUResultM = 0 on the forward path.
- A bubble must never produce a register write or memory write.
- Simultaneous StallE & FlushE: flush wins.

Test Plan:
1. Reset then ADD: rst held 2 cycles → all M outputs 0. Then RD1E = 5, RD2E = 7, ALUControlE = 0000, ALUSrcE = 0, RegWriteE = 1, RdE = 3 → next cycle ALUResultM = 12, RdM = 3, RegWriteM = 1, WriteDataM = 7.
2. Forwarding: ALUResultM = 0x10, ResultW = 0x20, RD1E = 1, ForwardAE = 10, ForwardBE = 01, SUB → ALUResult = 0xFFFFFFF0. With ForwardAE = 11 → SrcA = 1.
3. Branches:
   - PCE = 0x100, ImmExtE = 0xFFFFFFF8, BranchE = 1, BLT with SrcA = 0xFFFFFFFF, B = 1 → PCSrcE = 1, PCTargetE = 0xF8.
   - Same operands with BLTU → PCSrcE = 0.
   - BranchTypeE = 010 → PCSrcE = 0.
4. JALR: JumpE = JalrE = 1, SrcA = 0x203, Imm = 0 via ALUSrcE, ADD → PCTargetE = 0x202, PCSrcE = 1. Next cycle PCPlus4M carries PCPlus4E.
5. Stall/flush:
   - Load 0xAA into ALUResultM, then StallE = 1 with new inputs → outputs unchanged.
   - FlushE = 1 with RegWriteE = MemWriteE = 1 → RegWriteM = MemWriteM = 0, RdM = 0.
   - StallE = FlushE = 1 → flush result.
6. Shifts/SLT:
   - SrcA = 0x80000000, SrcB = 0x24, SRA → 0xF8000000 (shamt 4).
   - SLL with same operands → 0.
   - SLT(−1, 1) = 1; SLTU(−1, 1) = 0.

Source files
------------

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch comparator, redirect target
// and the EX/MEM pipeline register with flush/stall control.
module execute_stage #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               StallE,
    input  logic               FlushE,
    input  logic               RegWriteE,
    input  logic               MemWriteE,
    input  logic               a_typeE,
    input  logic               JumpE,
    input  logic               JalrE,
    input  logic               BranchE,
    input  logic [2:0]         BranchTypeE,
    input  logic [1:0]         ResultSrcE,
    input  logic [3:0]         ALUControlE,
    input  logic               ALUSrcE,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    input  logic [D_WIDTH-1:0] RD1E,
    input  logic [D_WIDTH-1:0] RD2E,
    input  logic [D_WIDTH-1:0] ImmExtE,
    input  logic [D_WIDTH-1:0] PCE,
    input  logic [D_WIDTH-1:0] PCPlus4E,
    input  logic [D_WIDTH-1:0] ResultW,
    input  logic [A_WIDTH-1:0] RdE,
    output logic               PCSrcE,
    output logic [D_WIDTH-1:0] PCTargetE,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic               a_typeM,
    output logic [1:0]         ResultSrcM,
    output logic [A_WIDTH-1:0] RdM,
    output logic [D_WIDTH-1:0] ALUResultM,
    output logic [D_WIDTH-1:0] WriteDataM,
    output logic [D_WIDTH-1:0] PCPlus4M
);

    logic [D_WIDTH-1:0] srca_s;
    logic [D_WIDTH-1:0] writedata_s;
    logic [D_WIDTH-1:0] srcb_s;
    logic [D_WIDTH-1:0] aluresult_s;
    logic [4:0]         shamt_s;
    logic               cond_s;

    logic               regwrite_r;
    logic               memwrite_r;
    logic               atype_r;
    logic [1:0]         resultsrc_r;
    logic [A_WIDTH-1:0] rd_r;
    logic [D_WIDTH-1:0] aluresult_r;
    logic [D_WIDTH-1:0] writedata_r;
    logic [D_WIDTH-1:0] pcplus4_r;

    // Forwarding muxes; the ALUResultM leg is this stage's own pipeline register
    always_comb begin
        srca_s      = RD1E;
        writedata_s = RD2E;
        case (ForwardAE)
            2'b01:   srca_s = ResultW;
            2'b10:   srca_s = aluresult_r;
            default: srca_s = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   writedata_s = ResultW;
            2'b10:   writedata_s = aluresult_r;
            default: writedata_s = RD2E;
        endcase
        if (ALUSrcE) begin
            srcb_s = ImmExtE;
        end else begin
            srcb_s = writedata_s;
        end
    end

    assign shamt_s = srcb_s[4:0];

    // ALU
    always_comb begin
        aluresult_s = {D_WIDTH{1'b0}};
        case (ALUControlE)
            4'b0000: aluresult_s = srca_s + srcb_s;
            4'b0001: aluresult_s = srca_s - srcb_s;
            4'b0010: aluresult_s = srca_s & srcb_s;
            4'b0011: aluresult_s = srca_s | srcb_s;
            4'b0100: aluresult_s = srca_s ^ srcb_s;
            4'b0101: aluresult_s = {{(D_WIDTH-1){1'b0}}, ($signed(srca_s) < $signed(srcb_s))};
            4'b0110: aluresult_s = {{(D_WIDTH-1){1'b0}}, (srca_s < srcb_s)};
            4'b0111: aluresult_s = srca_s << shamt_s;
            4'b1000: aluresult_s = srca_s >> shamt_s;
            4'b1001: aluresult_s = $unsigned($signed(srca_s) >>> shamt_s);
            4'b1010: aluresult_s = srcb_s;
            default: aluresult_s = {D_WIDTH{1'b0}};
        endcase
    end

    // Branch comparator works on the forwarded register operands, never the immediate
    always_comb begin
        cond_s = 1'b0;
        case (BranchTypeE)
            3'b000:  cond_s = (srca_s == writedata_s);
            3'b001:  cond_s = (srca_s != writedata_s);
            3'b100:  cond_s = ($signed(srca_s) <  $signed(writedata_s));
            3'b101:  cond_s = ($signed(srca_s) >= $signed(writedata_s));
            3'b110:  cond_s = (srca_s <  writedata_s);
            3'b111:  cond_s = (srca_s >= writedata_s);
            default: cond_s = 1'b0;
        endcase
    end

    // Redirect target: JALR takes the ALU sum with bit 0 cleared
    always_comb begin
        PCSrcE = JumpE | (BranchE & cond_s);
        if (JalrE) begin
            PCTargetE = aluresult_s & {{(D_WIDTH-1){1'b1}}, 1'b0};
        end else begin
            PCTargetE = PCE + ImmExtE;
        end
    end

    // EX/MEM register: reset, then flush (bubble), then stall (hold), else load
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            regwrite_r  <= 1'b0;
            memwrite_r  <= 1'b0;
            atype_r     <= 1'b0;
            resultsrc_r <= 2'b00;
            rd_r        <= {A_WIDTH{1'b0}};
            aluresult_r <= {D_WIDTH{1'b0}};
            writedata_r <= {D_WIDTH{1'b0}};
            pcplus4_r   <= {D_WIDTH{1'b0}};
        end else if (!StallE) begin
            regwrite_r  <= RegWriteE;
            memwrite_r  <= MemWriteE;
            atype_r     <= a_typeE;
            resultsrc_r <= ResultSrcE;
            rd_r        <= RdE;
            aluresult_r <= aluresult_s;
            writedata_r <= writedata_s;
            pcplus4_r   <= PCPlus4E;
        end
    end

    assign RegWriteM  = regwrite_r;
    assign MemWriteM  = memwrite_r;
    assign a_typeM    = atype_r;
    assign ResultSrcM = resultsrc_r;
    assign RdM        = rd_r;
    assign ALUResultM = aluresult_r;
    assign WriteDataM = writedata_r;
    assign PCPlus4M   = pcplus4_r;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed plan cases followed by random traffic,
// all checked against an arithmetic reference model of the RV32I execute rules.
module tb_execute_stage;

    typedef struct packed {
        logic        rst, stall, flush, regw, memw, atype, jump, jalr, branch;
        logic [2:0]  btype;
        logic [1:0]  rsrc;
        logic [3:0]  aluc;
        logic        alusrc;
        logic [1:0]  fa, fb;
        logic [31:0] rd1, rd2, imm, pc, pc4, resw;
        logic [4:0]  rd;
    } stim_t;

    typedef struct packed {
        logic        regw, memw, atype;
        logic [1:0]  rsrc;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4;
    } mstate_t;

    logic clk = 1'b0;
    logic rst, StallE, FlushE, RegWriteE, MemWriteE, a_typeE, JumpE, JalrE, BranchE, ALUSrcE;
    logic [2:0]  BranchTypeE;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [3:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
    logic [4:0]  RdE;
    logic        PCSrcE, RegWriteM, MemWriteM, a_typeM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;

    int tests = 0;
    int fails = 0;
    mstate_t model_m = '0;
    mstate_t exp_q[$];

    execute_stage #(.D_WIDTH(32), .A_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .a_typeE(a_typeE),
        .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE), .BranchTypeE(BranchTypeE),
        .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ResultW(ResultW), .RdE(RdE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .a_typeM(a_typeM),
        .ResultSrcM(ResultSrcM), .RdM(RdM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: signed compares done by biasing the sign bit
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bias = 32'h8000_0000;
        logic [31:0] ones = 32'hFFFF_FFFF;
        int unsigned sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return ((a ^ bias) < (b ^ bias)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return a << sh;
            4'd8:    return a >> sh;
            4'd9:    return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bias = 32'h8000_0000;
        logic lt_s = (a ^ bias) < (b ^ bias);
        case (t)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return lt_s;
            3'd5:    return !lt_s;
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] reg_v, input logic [31:0] resw);
        if (f == 2'b01) return resw;
        if (f == 2'b10) return model_m.alu;
        return reg_v;
    endfunction

    function automatic stim_t nop();
        stim_t s = '0;
        return s;
    endfunction

    // Drive one cycle's inputs, check the combinational redirect, queue the M-stage expectation
    task automatic step(input stim_t s);
        logic [31:0] a, wd, b, alu, tgt;
        logic        taken;
        mstate_t     nxt;
        @(negedge clk);
        rst = s.rst; StallE = s.stall; FlushE = s.flush;
        RegWriteE = s.regw; MemWriteE = s.memw; a_typeE = s.atype;
        JumpE = s.jump; JalrE = s.jalr; BranchE = s.branch; BranchTypeE = s.btype;
        ResultSrcE = s.rsrc; ALUControlE = s.aluc; ALUSrcE = s.alusrc;
        ForwardAE = s.fa; ForwardBE = s.fb;
        RD1E = s.rd1; RD2E = s.rd2; ImmExtE = s.imm; PCE = s.pc; PCPlus4E = s.pc4;
        ResultW = s.resw; RdE = s.rd;
        #1;
        a     = pick(s.fa, s.rd1, s.resw);
        wd    = pick(s.fb, s.rd2, s.resw);
        b     = s.alusrc ? s.imm : wd;
        alu   = ref_alu(s.aluc, a, b);
        taken = s.jump || (s.branch && ref_cond(s.btype, a, wd));
        tgt   = s.jalr ? {alu[31:1], 1'b0} : s.pc + s.imm;
        chk("PCSrcE", {31'd0, PCSrcE}, {31'd0, taken});
        chk("PCTargetE", PCTargetE, tgt);
        if (s.rst || s.flush) begin
            nxt = '0;
        end else if (s.stall) begin
            nxt = model_m;
        end else begin
            nxt = '{regw: s.regw, memw: s.memw, atype: s.atype, rsrc: s.rsrc, rd: s.rd,
                    alu: alu, wd: wd, pc4: s.pc4};
        end
        model_m = nxt;
        exp_q.push_back(nxt);
    endtask

    function automatic stim_t rnd_stim();
        stim_t s;
        s.rst    = ($urandom_range(0, 31) == 0);
        s.stall  = ($urandom_range(0, 5) == 0);
        s.flush  = ($urandom_range(0, 7) == 0);
        s.regw   = 1'($urandom); s.memw = 1'($urandom); s.atype = 1'($urandom);
        s.jump   = ($urandom_range(0, 5) == 0);
        s.jalr   = s.jump && 1'($urandom);
        s.branch = 1'($urandom);
        s.btype  = 3'($urandom); s.rsrc = 2'($urandom);
        s.aluc   = 4'($urandom_range(0, 15));
        s.alusrc = 1'($urandom);
        s.fa     = 2'($urandom); s.fb = 2'($urandom);
        s.rd1    = $urandom;
        s.rd2    = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
        s.imm    = $urandom; s.pc = $urandom; s.pc4 = $urandom; s.resw = $urandom;
        s.rd     = 5'($urandom);
        return s;
    endfunction

    // Monitor: after every rising edge compare the registered M outputs with the queue head
    initial begin
        mstate_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("RegWriteM",  {31'd0, RegWriteM}, {31'd0, e.regw});
                chk("MemWriteM",  {31'd0, MemWriteM}, {31'd0, e.memw});
                chk("a_typeM",    {31'd0, a_typeM},   {31'd0, e.atype});
                chk("ResultSrcM", {30'd0, ResultSrcM}, {30'd0, e.rsrc});
                chk("RdM",        {27'd0, RdM},       {27'd0, e.rd});
                chk("ALUResultM", ALUResultM, e.alu);
                chk("WriteDataM", WriteDataM, e.wd);
                chk("PCPlus4M",   PCPlus4M,   e.pc4);
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cnt;
        // 1: reset then ADD
        s = nop(); s.rst = 1'b1;
        step(s); step(s);
        s = nop(); s.rd1 = 32'd5; s.rd2 = 32'd7; s.regw = 1'b1; s.rd = 5'd3;
        step(s);
        // 2: forwarding (first load 0x10 into ALUResultM)
        s = nop(); s.rd1 = 32'h10;
        step(s);
        chk("plan1_alu", ALUResultM, 32'd12);
        chk("plan1_rd", {27'd0, RdM}, 32'd3);
        chk("plan1_wd", WriteDataM, 32'd7);
        s = nop(); s.rd1 = 32'd1; s.resw = 32'h20; s.fa = 2'b10; s.fb = 2'b01; s.aluc = 4'b0001;
        step(s);
        chk("plan2_load", ALUResultM, 32'h10);
        s = nop(); s.rd1 = 32'd1; s.fa = 2'b11; s.alusrc = 1'b1;
        step(s);
        chk("plan2_sub", ALUResultM, 32'hFFFF_FFF0);
        // 3: branches
        s = nop(); s.pc = 32'h100; s.imm = 32'hFFFF_FFF8; s.branch = 1'b1; s.btype = 3'b100;
        s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1;
        step(s);
        chk("plan2_fa11", ALUResultM, 32'd1);
        chk("plan3_blt_src", {31'd0, PCSrcE}, 32'd1);
        chk("plan3_blt_tgt", PCTargetE, 32'hF8);
        s.btype = 3'b110;
        step(s);
        chk("plan3_bltu", {31'd0, PCSrcE}, 32'd0);
        s.btype = 3'b010;
        step(s);
        chk("plan3_b010", {31'd0, PCSrcE}, 32'd0);
        // 4: JALR
        s = nop(); s.jump = 1'b1; s.jalr = 1'b1; s.rd1 = 32'h203; s.alusrc = 1'b1; s.pc4 = 32'h1234;
        step(s);
        chk("plan4_tgt", PCTargetE, 32'h202);
        chk("plan4_src", {31'd0, PCSrcE}, 32'd1);
        // 5: stall / flush
        s = nop(); s.rd1 = 32'hAA;
        step(s);
        chk("plan4_pc4", PCPlus4M, 32'h1234);
        s = nop(); s.stall = 1'b1; s.rd1 = 32'h55; s.regw = 1'b1; s.rd = 5'd4;
        step(s);
        chk("plan5_load", ALUResultM, 32'hAA);
        s = nop(); s.flush = 1'b1; s.regw = 1'b1; s.memw = 1'b1; s.rd = 5'd7;
        step(s);
        chk("plan5_stall", ALUResultM, 32'hAA);
        s = nop(); s.regw = 1'b1; s.rd = 5'd9;
        step(s);
        chk("plan5_flush_rw", {31'd0, RegWriteM}, 32'd0);
        chk("plan5_flush_mw", {31'd0, MemWriteM}, 32'd0);
        s = nop(); s.stall = 1'b1; s.flush = 1'b1;
        step(s);
        chk("plan5_rd9", {27'd0, RdM}, 32'd9);
        // 6: shifts and set-less-than
        s = nop(); s.rd1 = 32'h8000_0000; s.imm = 32'h24; s.alusrc = 1'b1; s.aluc = 4'b1001;
        step(s);
        chk("plan5_both_rd", {27'd0, RdM}, 32'd0);
        chk("plan5_both_rw", {31'd0, RegWriteM}, 32'd0);
        s.aluc = 4'b0111;
        step(s);
        chk("plan6_sra", ALUResultM, 32'hF800_0000);
        s = nop(); s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1; s.aluc = 4'b0101;
        step(s);
        chk("plan6_sll", ALUResultM, 32'd0);
        s.aluc = 4'b0110;
        step(s);
        chk("plan6_slt", ALUResultM, 32'd1);
        step(nop());
        chk("plan6_sltu", ALUResultM, 32'd0);
        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            step(rnd_stim());
        end
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 5) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
